// File: rtl/multiword_add_seq_if.sv
// Start/result handshake bundle for multiword_add_seq.
// The op_sub signal exists only when MWADD_SUB_EN is defined.
interface multiword_add_seq_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef MWADD_SUB_EN
  logic         op_sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
`ifdef MWADD_SUB_EN
    output op_sub,
`endif
    output start_valid, a, b, cin, res_ready,
    input  start_ready, res_valid, sum, cout, busy
  );

  modport slave (
`ifdef MWADD_SUB_EN
    input  op_sub,
`endif
    input  start_valid, a, b, cin, res_ready,
    output start_ready, res_valid, sum, cout, busy
  );
endinterface

// File: rtl/multiword_add_seq.sv
// WORDS*N-bit adder built from one N-bit parallel-prefix slice reused over WORDS cycles.
// Optional MWADD_SUB_EN adds an op_sub input selecting a - b instead of a + b + cin.

module para_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] g_tree;
  logic [N-1:0] p_tree;
  logic [N:0]   c;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign g[gi]   = a[gi] & b[gi];
      assign p[gi]   = a[gi] ^ b[gi];
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Kogge-Stone prefix: after the last level bit i holds the group (G,P) of bits 0..i.
  always_comb begin
    g_tree = g;
    p_tree = p;
    for (int k = 0; k < LEVELS; k++) begin
      g_tree = g_tree | (p_tree & (g_tree << (1 << k)));
      p_tree = p_tree & ((p_tree << (1 << k)) | ~({N{1'b1}} << (1 << k)));
    end
  end

  assign c    = {g_tree | (p_tree & {N{cin}}), cin};
  assign cout = c[N];
endmodule

module multiword_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus
);
  localparam int W  = N * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [W-1:0]  a_sh_reg, a_sh_next;
  logic [W-1:0]  b_sh_reg, b_sh_next;
  logic          carry_reg, carry_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [W-1:0]  sum_reg, sum_next;
  logic          cout_reg, cout_next;

  logic [N-1:0]  slice_sum;
  logic          slice_cout;
  logic [W-1:0]  b_in;
  logic          carry_in;
  logic          accept;
  logic          last_slice;
  logic [W-1:0]  sum_shift;

  para_carry_adder #(.N(N)) u_slice (
    .a    (a_sh_reg[N-1:0]),
    .b    (b_sh_reg[N-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

`ifdef MWADD_SUB_EN
  // Two's complement subtract: a + ~b + 1; cout then reads as "no borrow".
  assign b_in     = bus.op_sub ? ~bus.b : bus.b;
  assign carry_in = bus.op_sub ? 1'b1 : bus.cin;
`else
  assign b_in     = bus.b;
  assign carry_in = bus.cin;
`endif

  assign accept     = bus.start_valid && (state_reg == ST_IDLE);
  assign last_slice = (cnt_reg == CW'(WORDS - 1));
  // New slice enters at the top so the LSB slice ends up at the bottom after WORDS steps.
  assign sum_shift  = (sum_reg >> N) | (W'(slice_sum) << (W - N));

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          a_sh_next  = bus.a;
          b_sh_next  = b_in;
          carry_next = carry_in;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_next   = sum_shift;
        a_sh_next  = a_sh_reg >> N;
        b_sh_next  = b_sh_reg >> N;
        carry_next = slice_cout;
        cnt_next   = cnt_reg + CW'(1);
        if (last_slice) begin
          cout_next  = slice_cout;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
    end
  end

  assign bus.start_ready = (state_reg == ST_IDLE);
  assign bus.res_valid   = (state_reg == ST_DONE);
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.sum         = sum_reg;
  assign bus.cout        = cout_reg;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq at N=4, WORDS=4 (16-bit operands).
// With MWADD_SUB_EN it also covers subtract mode and a random run against a golden model.
module tb_multiword_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  multiword_add_seq_if #(.N(4), .WORDS(4)) bus ();

  multiword_add_seq #(.N(4), .WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Presents operands and returns just after the accept edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.cin = cv;
    bus.start_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = bus.start_ready;
      @(posedge clk);
    end
    #1;
    bus.start_valid = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    bus.cin = ~cv;
    chk("accept", acc, 1'b1);
  endtask

  task automatic wait_result(input string tag, input logic [15:0] es, input logic ec);
    int lat;
    logic got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      got = bus.res_valid;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    $display("op %s: sum=%h cout=%b latency=%0d", tag, bus.sum, bus.cout, lat);
  endtask

  task automatic take_result(input int stall);
    repeat (stall) @(negedge clk);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rv_fall", bus.res_valid, 1'b0);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.res_ready = 1'b0;
`ifdef MWADD_SUB_EN
    bus.op_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_start_ready", bus.start_ready, 1'b1);

    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_result("ffff_plus_1", 16'h0000, 1'b1);
    take_result(0);

    start_op(16'h1234, 16'h4321, 1'b1);
    wait_result("1234_plus_4321_c", 16'h5556, 1'b0);

    // Stall in DONE while a new operation is already offered.
    @(negedge clk);
    bus.a = 16'h0001;
    bus.b = 16'h0002;
    bus.cin = 1'b0;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_sum_%0d", i), bus.sum, 16'h5556);
      chk($sformatf("hold_cout_%0d", i), bus.cout, 1'b0);
      chk($sformatf("hold_ready_%0d", i), bus.start_ready, 1'b0);
      chk($sformatf("hold_valid_%0d", i), bus.res_valid, 1'b1);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_res_valid", bus.res_valid, 1'b0);
    chk("hs_start_ready", bus.start_ready, 1'b1);
    @(negedge clk);
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_busy", bus.busy, 1'b1);
    bus.start_valid = 1'b0;
    wait_result("b2b_1_plus_2", 16'h0003, 1'b0);
    take_result(2);

    // Abort with rst at the edge where cnt==2.
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_sum", bus.sum, 16'h0000);
    chk("abort_res_valid", bus.res_valid, 1'b0);
    chk("abort_start_ready", bus.start_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (8) begin
        @(posedge clk);
        #1;
        seen = seen | bus.res_valid;
      end
      chk("abort_no_pulse", seen, 1'b0);
    end
    start_op(16'h0F0F, 16'h00F1, 1'b0);
    wait_result("0f0f_plus_00f1", 16'h1000, 1'b0);
    take_result(0);

    // res_ready held high through RUN: DONE lasts a single cycle.
    @(negedge clk);
    bus.res_ready = 1'b1;
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_result("8000_plus_8000", 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    chk("auto_take_rv", bus.res_valid, 1'b0);
    bus.res_ready = 1'b0;

    start_op(16'hABCD, 16'h1111, 1'b0);
    wait_result("abcd_plus_1111", 16'hBCDE, 1'b0);
    take_result(1);

`ifdef MWADD_SUB_EN
    bus.op_sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0);
    wait_result("5_minus_7", 16'hFFFE, 1'b0);
    take_result(0);
    start_op(16'h0007, 16'h0005, 1'b0);
    wait_result("7_minus_5", 16'h0002, 1'b1);
    take_result(0);
    for (int t = 0; t < 1000; t++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic [16:0] model;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      model = {1'b0, ra} + {1'b0, (rs ? ~rb : rb)} + 17'(rs ? 1'b1 : rc);
      @(negedge clk);
      bus.op_sub = rs;
      start_op(ra, rb, rc);
      bus.op_sub = ~rs;
      wait_result($sformatf("rnd%0d", t), model[15:0], model[16]);
      take_result(int'($urandom_range(0, 3)));
    end
    bus.op_sub = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
